data_mem_responder: RTL and testbench

//   Memory-side responder for the pipeline's MEM-stage port (mem_addr, mem_write_data, mem_wr).

---
 rtl/data_mem_responder_if.sv | 19 +
 rtl/data_mem_responder.sv | 77 +++++++
 tb/tb_data_mem_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: MEM-stage request/response bundle between datapath and data memory
interface data_mem_responder_if;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_rvalid;
    logic        mem_stall;
    logic        mem_err;
    modport master (
        output mem_req, mem_wr, mem_addr, mem_write_data,
        input  mem_read_data, mem_rvalid, mem_stall, mem_err
    );
    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_write_data,
        output mem_read_data, mem_rvalid, mem_stall, mem_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency word SRAM responder that stalls the pipeline until each access completes
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input logic clk,
    input logic reset,
    data_mem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nxt;
    logic [3:0] count;
    logic [ADDR_WIDTH-1:0] idx_q, cur_idx;
    logic [31:0] data_q, cur_data, rdata_q;
    logic wr_q, oor_q, err_q, cur_wr, cur_oor, accept, go_resp;
    logic [31:0] sram [2**ADDR_WIDTH];
    logic unused_lsb;
    assign unused_lsb = ^bus.mem_addr[1:0];
    // LATENCY=1 reaches RESP straight from IDLE, so the response must use the live bus values then
    assign accept   = reset && state == IDLE && bus.mem_req;
    assign cur_idx  = accept ? bus.mem_addr[ADDR_WIDTH+1:2] : idx_q;
    assign cur_oor  = accept ? |bus.mem_addr[31:ADDR_WIDTH+2] : oor_q;
    assign cur_wr   = accept ? bus.mem_wr : wr_q;
    assign cur_data = accept ? bus.mem_write_data : data_q;
    assign go_resp  = state_nxt == RESP;
    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end
    // next-state: accept in IDLE, count down in WAIT, RESP always returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.mem_req ? (LATENCY == 1 ? RESP : WAIT) : IDLE;
            WAIT:    state_nxt = count == 4'd1 ? RESP : WAIT;
            default: state_nxt = IDLE;
        endcase
    end
    // latch the request, run the wait counter, and register read data on entry to RESP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            oor_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                count  <= 4'(LATENCY - 1);
                idx_q  <= cur_idx;
                data_q <= cur_data;
                wr_q   <= cur_wr;
                oor_q  <= cur_oor;
            end else if (state == WAIT) begin
                count <= count - 4'd1;
            end
            if (go_resp) begin
                err_q <= cur_oor;
                if (!cur_wr) rdata_q <= cur_oor ? 32'hDEADBEEF : sram[cur_idx];
            end
        end
    end
    // array write lands as the access enters RESP; out-of-range stores are dropped
    always_ff @(posedge clk) begin
        if (reset && go_resp && cur_wr && !cur_oor) sram[cur_idx] <= cur_data;
    end
    // outputs: stall while accepting or waiting, single-cycle ack and error in RESP
    always_comb begin
        bus.mem_stall     = accept || state == WAIT;
        bus.mem_rvalid    = state == RESP;
        bus.mem_err       = state == RESP && err_q;
        bus.mem_read_data = rdata_q;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of latency, stall, range handling, streaming and reset abort
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    int pulses;
    data_mem_responder_if bus ();
    data_mem_responder_if bus1 ();
    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (.clk(clk), .reset(reset), .bus(bus));
    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // one LATENCY=2 access starting at posedge+1 of cycle T; returns at posedge+1 of T+3 with req low
    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        bus.mem_req = 1'b1;
        bus.mem_wr = wr;
        bus.mem_addr = addr;
        bus.mem_write_data = data;
        @(negedge clk);
        check({tag, " stall T"}, 32'(bus.mem_stall), 32'd1);
        check({tag, " rvalid T"}, 32'(bus.mem_rvalid), 32'd0);
        next_cycle();
        @(negedge clk);
        check({tag, " stall T+1"}, 32'(bus.mem_stall), 32'd1);
        check({tag, " rvalid T+1"}, 32'(bus.mem_rvalid), 32'd0);
        next_cycle();
        @(negedge clk);
        check({tag, " rvalid T+2"}, 32'(bus.mem_rvalid), 32'd1);
        check({tag, " stall T+2"}, 32'(bus.mem_stall), 32'd0);
        check({tag, " err T+2"}, 32'(bus.mem_err), 32'(exp_err));
        check({tag, " rdata T+2"}, bus.mem_read_data, exp_rdata);
        next_cycle();
        bus.mem_req = 1'b0;
        bus.mem_wr = 1'b0;
    endtask

    initial begin
        bus.mem_req = 1'b1;
        bus.mem_wr = 1'b1;
        bus.mem_addr = 32'h10;
        bus.mem_write_data = 32'h0;
        bus1.mem_req = 1'b0;
        bus1.mem_wr = 1'b0;
        bus1.mem_addr = 32'h0;
        bus1.mem_write_data = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset stall", 32'(bus.mem_stall), 32'd0);
            check("reset rvalid", 32'(bus.mem_rvalid), 32'd0);
        end
        bus.mem_req = 1'b0;
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check("post-reset stall", 32'(bus.mem_stall), 32'd0);
        check("post-reset rvalid", 32'(bus.mem_rvalid), 32'd0);
        check("post-reset err", 32'(bus.mem_err), 32'd0);
        check("post-reset rdata", bus.mem_read_data, 32'd0);
        next_cycle();
        access(1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0, 1'b0, "wr 0x0");
        access(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 1'b0, "wr 0x10");
        access(1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 1'b0, "rd 0x10");
        access(1'b0, 32'h0000_0013, 32'h0, 32'hCAFE_F00D, 1'b0, "rd 0x13");
        access(1'b0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 1'b1, "rd oor");
        access(1'b1, 32'h0000_1000, 32'h5555_5555, 32'hDEAD_BEEF, 1'b1, "wr oor");
        access(1'b0, 32'h0000_0000, 32'h0, 32'h1111_1111, 1'b0, "rd 0x0");
        // request held high across four back-to-back reads: acks at cycles 2, 5, 8, 11
        pulses = 0;
        bus.mem_req = 1'b1;
        bus.mem_wr = 1'b0;
        bus.mem_addr = 32'h10;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("stream rvalid c%0d", i), 32'(bus.mem_rvalid), 32'((i % 3) == 2));
            if (bus.mem_rvalid) pulses++;
            next_cycle();
        end
        bus.mem_req = 1'b0;
        check("stream pulse count", 32'(pulses), 32'd4);
        check("stream rdata", bus.mem_read_data, 32'hCAFE_F00D);
        access(1'b1, 32'h0000_0020, 32'h1234_5678, 32'hCAFE_F00D, 1'b0, "wr 0x20");
        // abort a write one cycle in with reset
        bus.mem_req = 1'b1;
        bus.mem_wr = 1'b1;
        bus.mem_addr = 32'h20;
        bus.mem_write_data = 32'h0000_0BAD;
        next_cycle();
        reset = 1'b0;
        bus.mem_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("abort rvalid c%0d", i), 32'(bus.mem_rvalid), 32'd0);
            check($sformatf("abort stall c%0d", i), 32'(bus.mem_stall), 32'd0);
            next_cycle();
        end
        reset = 1'b1;
        next_cycle();
        access(1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678, 1'b0, "rd 0x20 after abort");
        // LATENCY=1 instance: stall only in the request cycle, ack one cycle later
        bus1.mem_req = 1'b1;
        bus1.mem_wr = 1'b1;
        bus1.mem_addr = 32'h40;
        bus1.mem_write_data = 32'hA5A5_A5A5;
        @(negedge clk);
        check("lat1 wr stall T", 32'(bus1.mem_stall), 32'd1);
        check("lat1 wr rvalid T", 32'(bus1.mem_rvalid), 32'd0);
        next_cycle();
        @(negedge clk);
        check("lat1 wr rvalid T+1", 32'(bus1.mem_rvalid), 32'd1);
        check("lat1 wr stall T+1", 32'(bus1.mem_stall), 32'd0);
        next_cycle();
        bus1.mem_wr = 1'b0;
        @(negedge clk);
        check("lat1 rd stall T", 32'(bus1.mem_stall), 32'd1);
        check("lat1 rd rvalid T", 32'(bus1.mem_rvalid), 32'd0);
        next_cycle();
        bus1.mem_req = 1'b0;
        @(negedge clk);
        check("lat1 rd rvalid T+1", 32'(bus1.mem_rvalid), 32'd1);
        check("lat1 rd rdata T+1", bus1.mem_read_data, 32'hA5A5_A5A5);
        check("lat1 rd err T+1", 32'(bus1.mem_err), 32'd0);
        next_cycle();
        @(negedge clk);
        check("lat1 idle rvalid", 32'(bus1.mem_rvalid), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
